// File: rtl/dram_cmd_responder.sv
// dram_cmd_responder: single-command DRAM bank model. It accepts one command
// at a time, waits out that command's latency, then acknowledges it with a
// one-cycle pulse. Bank open/row state, read address and refresh count are
// updated on the acknowledge.
module dram_cmd_responder #(
    parameter int NUMBER_OF_BANKS = 8,
    parameter int NUMBER_OF_ROWS  = 128,
    parameter int NUMBER_OF_COLS  = 8,
    parameter int T_RCD           = 3,
    parameter int T_CL            = 2,
    parameter int T_RP            = 3,
    parameter int T_RFC           = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cmd_req,
    input  logic [1:0]                            cmd,
    input  logic [$clog2(NUMBER_OF_BANKS)-1:0]    bank_id,
    input  logic [$clog2(NUMBER_OF_ROWS)-1:0]     row_id,
    input  logic [$clog2(NUMBER_OF_COLS)-1:0]     col_id,
    output logic                                  cmd_ack,
    output logic                                  cmd_err,
    output logic                                  busy,
    output logic [NUMBER_OF_BANKS-1:0]            bank_open,
    output logic                                  rd_valid,
    output logic [$clog2(NUMBER_OF_BANKS)+$clog2(NUMBER_OF_ROWS)+$clog2(NUMBER_OF_COLS)-1:0] rd_addr,
    output logic [15:0]                           ref_count
);

    localparam int BW  = $clog2(NUMBER_OF_BANKS);
    localparam int RW  = $clog2(NUMBER_OF_ROWS);
    localparam int CLW = $clog2(NUMBER_OF_COLS);

    // Counter only ever holds LAT-1, so it is sized from the longest latency.
    localparam int MAX_AB  = (T_RCD > T_CL) ? T_RCD : T_CL;
    localparam int MAX_CD  = (T_RP > T_RFC) ? T_RP : T_RFC;
    localparam int MAX_LAT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW      = $clog2(MAX_LAT + 1);

    localparam logic [1:0] CMD_ACT = 2'b00;
    localparam logic [1:0] CMD_RD  = 2'b01;
    localparam logic [1:0] CMD_REF = 2'b10;
    localparam logic [1:0] CMD_PRE = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   lat_cnt;
    logic [CW-1:0]   lat_load;
    logic [1:0]      lat_cmd;
    logic [BW-1:0]   lat_bank;
    logic [RW-1:0]   lat_row;
    logic [CLW-1:0]  lat_col;
    logic [RW-1:0]   open_row [NUMBER_OF_BANKS];
    logic            done;

    assign busy = (state != IDLE);
    assign done = (state == BUSY) && (lat_cnt == '0);

    // Latency preload for the incoming command (LAT-1).
    always_comb begin
        lat_load = '0;
        case (cmd)
            CMD_ACT: lat_load = CW'(T_RCD - 1);
            CMD_RD:  lat_load = CW'(T_CL - 1);
            CMD_REF: lat_load = CW'(T_RFC - 1);
            CMD_PRE: lat_load = CW'(T_RP - 1);
            default: lat_load = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: accept only from IDLE, ACK always lasts exactly one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_req) state_nxt = BUSY;
            BUSY:    if (lat_cnt == '0) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command latch, latency countdown and the completion effects on bank state.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_cnt   <= '0;
            lat_cmd   <= '0;
            lat_bank  <= '0;
            lat_row   <= '0;
            lat_col   <= '0;
            cmd_ack   <= 1'b0;
            cmd_err   <= 1'b0;
            rd_valid  <= 1'b0;
            rd_addr   <= '0;
            bank_open <= '0;
            ref_count <= '0;
            for (int i = 0; i < NUMBER_OF_BANKS; i++) open_row[i] <= '0;
        end else begin
            cmd_ack  <= 1'b0;
            cmd_err  <= 1'b0;
            rd_valid <= 1'b0;

            if (state == IDLE && cmd_req) begin
                lat_cmd  <= cmd;
                lat_bank <= bank_id;
                lat_row  <= row_id;
                lat_col  <= col_id;
                lat_cnt  <= lat_load;
            end else if (state == BUSY && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - 1'b1;
            end

            // Effects land on the same edge that enters ACK, so they are
            // visible for the whole ACK cycle alongside cmd_ack.
            if (done) begin
                cmd_ack <= 1'b1;
                case (lat_cmd)
                    CMD_ACT: begin
                        if (bank_open[lat_bank]) begin
                            cmd_err <= 1'b1;
                        end else begin
                            bank_open[lat_bank] <= 1'b1;
                            open_row[lat_bank]  <= lat_row;
                        end
                    end
                    CMD_RD: begin
                        if (bank_open[lat_bank]) begin
                            rd_valid <= 1'b1;
                            rd_addr  <= {lat_bank, open_row[lat_bank], lat_col};
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                    CMD_REF: begin
                        cmd_err   <= |bank_open;
                        bank_open <= '0;
                        if (ref_count != 16'hFFFF) ref_count <= ref_count + 16'd1;
                    end
                    CMD_PRE: begin
                        bank_open[lat_bank] <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
